// File: rtl/wd_supervisor_pkg.sv
// Shared types and constants for the watchdog supervisor.
package wd_supervisor_pkg;

  localparam int STATE_W = 3;
  localparam int FAULT_W = 8;

  localparam logic [FAULT_W-1:0] FAULT_MAX = 8'd255;

  typedef enum logic [STATE_W-1:0] {
    ST_DISABLED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_TRIPPED  = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_WAIT_ARM = 3'd4,
    ST_RECOVER  = 3'd5
  } wd_state_e;

  // Trip counter saturates instead of wrapping.
  function automatic logic [FAULT_W-1:0] sat_inc(input logic [FAULT_W-1:0] value);
    if (value == FAULT_MAX) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/wd_supervisor_if.sv
// Pin bundle between the supervisor (master) and the watchdog timer (slave).
interface wd_supervisor_if;

  logic wd_heartbeat;
  logic wd_enable;
  logic wd_force_reset;
  logic wd_triggered;

  modport master (
    output wd_heartbeat,
    output wd_enable,
    output wd_force_reset,
    input  wd_triggered
  );

  modport slave (
    input  wd_heartbeat,
    input  wd_enable,
    input  wd_force_reset,
    output wd_triggered
  );

endinterface

// File: rtl/wd_supervisor_heartbeat_collector.sv
// Tracks which enabled clients have kicked in the current window, fires the
// heartbeat when all have, enforces the one-cycle gap and snapshots missers.
module heartbeat_collector #(
  parameter int NUM_CLIENTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] client_enable,
  input  logic [NUM_CLIENTS-1:0] client_kick,
  input  logic                   active,
  input  logic                   clear,
  input  logic                   capture,
  output logic                   heartbeat,
  output logic [NUM_CLIENTS-1:0] missing_mask
);

  logic [NUM_CLIENTS-1:0] seen_r;
  logic [NUM_CLIENTS-1:0] seen_n;
  logic [NUM_CLIENTS-1:0] missing_r;
  logic [NUM_CLIENTS-1:0] kick_s;
  logic [NUM_CLIENTS-1:0] cand_s;
  logic                   hb_r;
  logic                   hb_n;
  logic                   prior_full_s;
  logic                   complete_s;

  assign kick_s       = client_kick & client_enable;
  assign cand_s       = (seen_r | client_kick) & client_enable;
  assign prior_full_s = ((seen_r & client_enable) == client_enable);
  assign complete_s   = active && (client_enable != '0) && (cand_s == client_enable) && !hb_r;

  // Window accounting. A completion that was deferred by the gap rule was
  // already full before this cycle, so this cycle's kicks open the next window.
  always_comb begin
    seen_n = seen_r & client_enable;
    hb_n   = 1'b0;
    if (clear) begin
      seen_n = '0;
    end else if (complete_s) begin
      hb_n   = 1'b1;
      seen_n = prior_full_s ? kick_s : '0;
    end else if (active) begin
      seen_n = cand_s;
    end else begin
      seen_n = seen_r & client_enable;
    end
  end

  // Seen mask, heartbeat pulse and missing-client snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r    <= '0;
      hb_r      <= 1'b0;
      missing_r <= '0;
    end else begin
      seen_r <= seen_n;
      hb_r   <= hb_n;
      if (capture) begin
        missing_r <= client_enable & ~seen_r;
      end else begin
        missing_r <= missing_r;
      end
    end
  end

  assign heartbeat    = hb_r;
  assign missing_mask = missing_r;

endmodule

// File: rtl/wd_supervisor.sv
// Watchdog supervisor: gathers client kicks, drives the watchdog and handles
// trip / holdoff / re-arm. WD_SUPERVISOR_AUTO_REARM_EN enables automatic re-arm.
module wd_supervisor
  import wd_supervisor_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int MAX_AUTO_REARM = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  wd_supervisor_if.master        wd,
  input  logic [NUM_CLIENTS-1:0] client_enable,
  input  logic [NUM_CLIENTS-1:0] client_kick,
  input  logic                   arm_req,
  output logic                   rf_mute,
  output logic [STATE_W-1:0]     state,
  output logic [FAULT_W-1:0]     fault_count,
  output logic [NUM_CLIENTS-1:0] missing_mask
);

`ifdef WD_SUPERVISOR_AUTO_REARM_EN
  localparam bit AUTO_REARM = 1'b1;
`else
  localparam bit AUTO_REARM = 1'b0;
`endif

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  wd_state_e            state_r;
  wd_state_e            state_n;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic [FAULT_W-1:0]   fault_count_r;
  logic                 enable_r;
  logic                 enable_n;
  logic                 mute_r;
  logic                 mute_n;
  logic                 force_r;
  logic                 force_n;
  logic                 first_armed_r;
  logic                 en_any_s;
  logic                 trip_s;
  logic                 active_s;
  logic                 auto_ok_s;
  logic                 hb_s;

  assign en_any_s = (client_enable != '0);
  // The watchdog may still show triggered in the first ARMED cycle after a
  // force_reset; that sample must not count as a new trip.
  assign trip_s   = (state_r == ST_ARMED) && wd.wd_triggered && !first_armed_r;
  assign active_s = (state_r == ST_ARMED) && !trip_s && en_any_s;
  // fault_count already includes the current trip here, so "<=" allows
  // MAX_AUTO_REARM automatic recoveries.
  assign auto_ok_s = AUTO_REARM && (fault_count_r <= FAULT_W'(MAX_AUTO_REARM));

  heartbeat_collector #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_collector (
    .clk           (clk),
    .rst           (rst),
    .client_enable (client_enable),
    .client_kick   (client_kick),
    .active        (active_s),
    .clear         ((state_r == ST_DISABLED) || (state_r == ST_RECOVER)),
    .capture       (state_r == ST_TRIPPED),
    .heartbeat     (hb_s),
    .missing_mask  (missing_mask)
  );

  // Next-state logic plus the output values that go with the next state.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_DISABLED: begin
        if (en_any_s) state_n = ST_ARMED;
        else          state_n = ST_DISABLED;
      end
      ST_ARMED: begin
        if (trip_s)         state_n = ST_TRIPPED;
        else if (!en_any_s) state_n = ST_DISABLED;
        else                state_n = ST_ARMED;
      end
      ST_TRIPPED: begin
        state_n = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_cnt_r == HOLD_LAST) begin
          if (auto_ok_s) state_n = ST_RECOVER;
          else           state_n = ST_WAIT_ARM;
        end else begin
          state_n = ST_HOLDOFF;
        end
      end
      ST_WAIT_ARM: begin
        if (arm_req)        state_n = ST_RECOVER;
        else if (!en_any_s) state_n = ST_DISABLED;
        else                state_n = ST_WAIT_ARM;
      end
      ST_RECOVER: begin
        state_n = ST_ARMED;
      end
      default: begin
        state_n = ST_DISABLED;
      end
    endcase
    enable_n = (state_n != ST_DISABLED);
    mute_n   = (state_n inside {ST_TRIPPED, ST_HOLDOFF, ST_WAIT_ARM, ST_RECOVER});
    force_n  = (state_n == ST_RECOVER);
  end

  // State, holdoff counter, trip counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_DISABLED;
      hold_cnt_r    <= '0;
      fault_count_r <= '0;
      enable_r      <= 1'b0;
      mute_r        <= 1'b0;
      force_r       <= 1'b0;
      first_armed_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      enable_r      <= enable_n;
      mute_r        <= mute_n;
      force_r       <= force_n;
      first_armed_r <= (state_r == ST_RECOVER);
      if (state_r == ST_HOLDOFF) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= '0;
      end
      if (state_r == ST_TRIPPED) begin
        fault_count_r <= sat_inc(fault_count_r);
      end else begin
        fault_count_r <= fault_count_r;
      end
    end
  end

  assign wd.wd_heartbeat   = hb_s;
  assign wd.wd_enable      = enable_r;
  assign wd.wd_force_reset = force_r;
  assign rf_mute           = mute_r;
  assign state             = state_r;
  assign fault_count       = fault_count_r;

endmodule

// File: tb/tb_wd_supervisor.sv
// Randomised and directed bench for wd_supervisor against a cycle-level
// behavioural model of the supervisor's rules.
module tb_wd_supervisor;

  localparam int NC   = 4;
  localparam int HC   = 16;
  localparam int MAXR = 3;
`ifdef WD_SUPERVISOR_AUTO_REARM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] en;
  logic [NC-1:0] kick;
  logic          arm;
  logic          trig;
  logic          rf_mute;
  logic [2:0]    state;
  logic [7:0]    fault_count;
  logic [NC-1:0] missing_mask;

  wd_supervisor_if wd_bus();
  assign wd_bus.wd_triggered = trig;

  always #5 clk = ~clk;

  wd_supervisor #(
    .NUM_CLIENTS    (NC),
    .HOLDOFF_CYCLES (HC),
    .MAX_AUTO_REARM (MAXR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wd            (wd_bus),
    .client_enable (en),
    .client_kick   (kick),
    .arm_req       (arm),
    .rf_mute       (rf_mute),
    .state         (state),
    .fault_count   (fault_count),
    .missing_mask  (missing_mask)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0..5 plus the set of clients heard from this window.
  int            m_state = 0;
  logic [NC-1:0] m_seen = '0;
  logic [NC-1:0] m_missing = '0;
  logic          m_hb = 1'b0;
  logic          m_fresh = 1'b0;
  int            m_fault = 0;
  int            m_hold = 0;
  logic          hb_prev = 1'b0;

  task automatic model_update();
    int prev;
    int nxt;
    logic [NC-1:0] heard;
    if (rst) begin
      m_state = 0; m_seen = '0; m_missing = '0; m_hb = 1'b0;
      m_fresh = 1'b0; m_fault = 0; m_hold = 0;
    end else begin
      prev = m_state;
      nxt  = prev;
      m_hb = 1'b0;
      case (prev)
        0: begin
          nxt = (en != '0) ? 1 : 0;
          m_seen = '0;
        end
        1: begin
          if (trig && !m_fresh) nxt = 2;
          else if (en == '0)    nxt = 0;
          else                  nxt = 1;
          if (nxt == 1) begin
            heard = (m_seen | kick) & en;
            if (heard == en && !(hb_prev_model())) begin
              // window was already complete before this cycle: new kicks start the next one
              m_seen = ((m_seen & en) == en) ? (kick & en) : '0;
              m_hb = 1'b1;
            end else begin
              m_seen = heard;
            end
          end else begin
            m_seen = m_seen & en;
          end
        end
        2: begin
          m_missing = en & ~m_seen;
          m_fault = (m_fault < 255) ? m_fault + 1 : 255;
          m_seen = m_seen & en;
          m_hold = 0;
          nxt = 3;
        end
        3: begin
          m_hold++;
          m_seen = m_seen & en;
          if (m_hold == HC) nxt = (AUTO && (m_fault - 1) < MAXR) ? 5 : 4;
        end
        4: begin
          m_seen = m_seen & en;
          if (arm)           nxt = 5;
          else if (en == '0) nxt = 0;
          else               nxt = 4;
        end
        5: begin
          m_seen = '0;
          nxt = 1;
        end
        default: nxt = 0;
      endcase
      m_fresh = (prev == 5);
      m_state = nxt;
    end
  endtask

  // Heartbeat emitted by the model in the cycle before this edge.
  logic m_hb_last = 1'b0;
  function automatic logic hb_prev_model();
    return m_hb_last;
  endfunction

  task automatic compare_all();
    check("state",        32'(state),                 32'(m_state));
    check("heartbeat",    32'(wd_bus.wd_heartbeat),   32'(m_hb));
    check("wd_enable",    32'(wd_bus.wd_enable),      32'(m_state != 0));
    check("force_reset",  32'(wd_bus.wd_force_reset), 32'(m_state == 5));
    check("rf_mute",      32'(rf_mute),               32'(m_state inside {2, 3, 4, 5}));
    check("fault_count",  32'(fault_count),           32'(m_fault));
    check("missing_mask", 32'(missing_mask),          32'(m_missing));
    check("hb_gap",       32'(hb_prev & wd_bus.wd_heartbeat), 32'd0);
    hb_prev = wd_bus.wd_heartbeat;
  endtask

  task automatic step();
    @(posedge clk);
    m_hb_last = m_hb;
    model_update();
    if (rst) m_hb_last = 1'b0;
    #1;
    compare_all();
  endtask

  // Trip from ARMED and follow the trip sequence until it leaves TRIPPED/HOLDOFF.
  task automatic run_trip(output int final_state);
    int n;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while ((state == 3'd2 || state == 3'd3) && n < 40) begin
      step();
      n++;
    end
    check("trip_bounded", 32'(n < 40), 32'd1);
    final_state = int'(state);
  endtask

  logic [5:0] gap_pat;
  int n;
  int fs;

  initial begin
    rst = 1'b1; en = '0; kick = '0; arm = 1'b0; trig = 1'b0;
    step();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_hb",    32'(wd_bus.wd_heartbeat), 32'd0);
    check("rst_en",    32'(wd_bus.wd_enable), 32'd0);
    check("rst_mute",  32'(rf_mute), 32'd0);
    check("rst_fault", 32'(fault_count), 32'd0);
    rst = 1'b0;

    // basic heartbeat
    en = 4'b0101;
    step();
    check("basic_armed", 32'(state), 32'd1);
    kick = 4'b0001;
    step();
    check("basic_hb_early", 32'(wd_bus.wd_heartbeat), 32'd0);
    kick = 4'b0100;
    step();
    check("basic_hb", 32'(wd_bus.wd_heartbeat), 32'd1);
    check("basic_state", 32'(state), 32'd1);
    kick = 4'b0000;
    step();
    check("basic_hb_single", 32'(wd_bus.wd_heartbeat), 32'd0);

    // gap rule
    gap_pat = 6'b010101;
    en = 4'b0001;
    kick = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      check("gap_hb", 32'(wd_bus.wd_heartbeat), 32'(gap_pat[i]));
    end
    kick = 4'b0000;

    // trip path
    en = 4'b1111;
    step();
    kick = 4'b0001; step();
    kick = 4'b0010; step();
    kick = 4'b0000; step();
    trig = 1'b1;
    step();
    check("trip_state", 32'(state), 32'd2);
    check("trip_mute",  32'(rf_mute), 32'd1);
    trig = 1'b0;
    step();
    check("holdoff_state", 32'(state), 32'd3);
    check("trip_missing",  32'(missing_mask), 32'hC);
    check("trip_fault",    32'(fault_count), 32'd1);
    n = 0;
    while (state == 3'd3 && n < 40) begin
      n++;
      step();
    end
    check("holdoff_len", 32'(n), 32'd16);
`ifndef WD_SUPERVISOR_AUTO_REARM_EN
    check("after_holdoff", 32'(state), 32'd4);
    // operator re-arm with triggered still high
    arm = 1'b1; trig = 1'b1;
    step();
    check("rearm_state", 32'(state), 32'd5);
    check("rearm_force", 32'(wd_bus.wd_force_reset), 32'd1);
    check("rearm_mute",  32'(rf_mute), 32'd1);
    arm = 1'b0;
    step();
    check("rearm_armed", 32'(state), 32'd1);
    check("rearm_unmute", 32'(rf_mute), 32'd0);
    check("rearm_force_once", 32'(wd_bus.wd_force_reset), 32'd0);
    step();
    check("no_retrip", 32'(state), 32'd1);
    trig = 1'b0;
    step();
`else
    check("after_holdoff", 32'(state), 32'd5);
    step(); step();
    run_trip(fs);
    check("auto_trip2", 32'(fs), 32'd5);
    step(); step();
    run_trip(fs);
    check("auto_trip3", 32'(fs), 32'd5);
    step(); step();
    run_trip(fs);
    check("auto_trip4", 32'(fs), 32'd4);
    check("auto_fault4", 32'(fault_count), 32'd4);
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    check("auto_rearmed", 32'(state), 32'd1);
`endif

    // reset in the fifth HOLDOFF cycle
    trig = 1'b1;
    step();
    trig = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_holdoff", 32'(state), 32'd3);
    rst = 1'b1;
    step();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_fault", 32'(fault_count), 32'd0);
    check("mid_rst_mute",  32'(rf_mute), 32'd0);
    check("mid_rst_en",    32'(wd_bus.wd_enable), 32'd0);
    check("mid_rst_force", 32'(wd_bus.wd_force_reset), 32'd0);
    check("mid_rst_miss",  32'(missing_mask), 32'd0);
    rst = 1'b0;

    // randomised traffic
    en = 4'b1011;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) en = 4'($urandom_range(0, 15));
      kick = 4'($urandom_range(0, 15));
      arm  = ($urandom_range(0, 15) == 0);
      trig = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    // repeated trips to saturate fault_count
    en = 4'b1111; kick = '0; trig = 1'b1; arm = 1'b1;
    for (int i = 0; i < 5400; i++) step();
    check("fault_sat", 32'(fault_count), 32'd255);
    trig = 1'b0; arm = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
